gpr_write_arbiter: RTL and testbench

- Shares the single GPR register-file write port between ALU results and load-data results in the write-back stage.
- Load returns can never be stalled, so they always win the port. ALU results that lose are held in an in-order FIFO and written when the port is free.
- Provides a lookup port so decode/forwarding logic can see buffered, not-yet-written values.
- Provides a drained flag that the sleep/interrupt sequencer checks before gating the core.

---
 rtl/gpr_write_arbiter.sv | 125 ++++++++++++
 tb/tb_gpr_write_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/gpr_write_arbiter.sv
// rtl/gpr_write_arbiter.sv - shares the GPR write port between load returns and ALU results
// Loads always win; losing ALU results wait in an in-order FIFO that the lookup port exposes.
module gpr_write_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDR_W-1:0]          alu_dest,
  input  logic [DATA_W-1:0]          alu_data,
  input  logic                       mem_valid,
  input  logic [ADDR_W-1:0]          mem_dest,
  input  logic [DATA_W-1:0]          mem_data,
  output logic                       gpr_we,
  output logic [ADDR_W-1:0]          gpr_waddr,
  output logic [DATA_W-1:0]          gpr_wdata,
  input  logic [ADDR_W-1:0]          lk_addr,
  output logic                       lk_hit,
  output logic [DATA_W-1:0]          lk_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drained
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fifo_dest_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              gpr_we_q, gpr_we_d;
  logic [ADDR_W-1:0] gpr_waddr_q, gpr_waddr_d;
  logic [DATA_W-1:0] gpr_wdata_q, gpr_wdata_d;

  logic              fifo_empty;
  logic              do_push;
  logic              do_pop;
  logic [PTR_W-1:0]  lk_idx;

  // Ready looks only at occupancy so it never depends on the same-cycle pop.
  assign fifo_empty = (count_q == '0);
  assign alu_ready  = !reset && (count_q < CNT_W'(DEPTH));
  assign do_pop     = !mem_valid && !fifo_empty;
  assign do_push    = alu_valid && alu_ready && (mem_valid || !fifo_empty);

  always_comb begin
    gpr_we_d    = 1'b0;
    gpr_waddr_d = gpr_waddr_q;
    gpr_wdata_d = gpr_wdata_q;
    if (mem_valid) begin
      gpr_we_d    = 1'b1;
      gpr_waddr_d = mem_dest;
      gpr_wdata_d = mem_data;
    end else if (!fifo_empty) begin
      gpr_we_d    = 1'b1;
      gpr_waddr_d = fifo_dest_q[rd_ptr_q];
      gpr_wdata_d = fifo_data_q[rd_ptr_q];
    end else if (alu_valid) begin
      gpr_we_d    = 1'b1;
      gpr_waddr_d = alu_dest;
      gpr_wdata_d = alu_data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      gpr_we_q    <= 1'b0;
      gpr_waddr_q <= '0;
      gpr_wdata_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      gpr_we_q    <= gpr_we_d;
      gpr_waddr_q <= gpr_waddr_d;
      gpr_wdata_q <= gpr_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_dest_q[wr_ptr_q] <= alu_dest;
      fifo_data_q[wr_ptr_q] <= alu_data;
    end
  end

  // Walk oldest to youngest so the last match (youngest) wins over older ones.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    lk_idx  = rd_ptr_q;
    if (gpr_we_q && (gpr_waddr_q == lk_addr)) begin
      lk_hit  = 1'b1;
      lk_data = gpr_wdata_q;
    end
    for (int k = 0; k < DEPTH; k++) begin
      lk_idx = rd_ptr_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (fifo_dest_q[lk_idx] == lk_addr)) begin
        lk_hit  = 1'b1;
        lk_data = fifo_data_q[lk_idx];
      end
    end
  end

  assign gpr_we    = gpr_we_q;
  assign gpr_waddr = gpr_waddr_q;
  assign gpr_wdata = gpr_wdata_q;
  assign count     = count_q;
  assign drained   = fifo_empty && !gpr_we_q;

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// tb/tb_gpr_write_arbiter.sv - scoreboard bench for gpr_write_arbiter
module tb_gpr_write_arbiter;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_dest;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic [4:0]  mem_dest;
  logic [31:0] mem_data;
  logic        gpr_we;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic [4:0]  lk_addr;
  logic        lk_hit;
  logic [31:0] lk_data;
  logic [2:0]  count;
  logic        drained;

  wr_t sbq[$];
  int  total = 0;
  int  bad   = 0;

  gpr_write_arbiter #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data),
    .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
    .count(count), .drained(drained)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: drive, check pre-edge state, predict, then check the registered write.
  task automatic step(input logic mv, input logic [4:0] md, input logic [31:0] mdat,
                      input logic av, input logic [4:0] ad, input logic [31:0] adat,
                      output logic acc);
    int   n;
    logic exp_we;
    wr_t  w;
    mem_valid = mv; mem_dest = md; mem_data = mdat;
    alu_valid = av; alu_dest = ad; alu_data = adat;
    #1;
    n = sbq.size();
    check("count", 64'(count), 64'(n));
    check("alu_ready", 64'(alu_ready), 64'(n < DEPTH));
    acc    = av && (n < DEPTH);
    exp_we = mv || (n > 0) || av;
    if (acc) sbq.push_back({ad, adat});
    @(posedge clk); #1;
    check("gpr_we", 64'(gpr_we), 64'(exp_we));
    if (exp_we && mv) begin
      check("mem_waddr", 64'(gpr_waddr), 64'(md));
      check("mem_wdata", 64'(gpr_wdata), 64'(mdat));
    end else if (exp_we && sbq.size() > 0) begin
      w = sbq.pop_front();
      check("alu_waddr", 64'(gpr_waddr), 64'(w.a));
      check("alu_wdata", 64'(gpr_wdata), 64'(w.d));
    end
    check("drained", 64'(drained), 64'((sbq.size() == 0) && !exp_we));
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic a;
    int   nxt, acc_cnt;
    logic pend;
    logic [4:0]  pd;
    logic [31:0] pv;

    reset = 1'b1; alu_valid = 0; alu_dest = 0; alu_data = 0;
    mem_valid = 0; mem_dest = 0; mem_data = 0; lk_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 64'(gpr_we), 64'd0);
    check("rst_waddr", 64'(gpr_waddr), 64'd0);
    check("rst_wdata", 64'(gpr_wdata), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_drained", 64'(drained), 64'd1);
    check("rst_ready", 64'(alu_ready), 64'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // ALU bypass on idle FIFO
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h11, a);
    idle(1);

    // Simultaneous load and ALU: load first, ALU next
    step(1'b1, 5'd5, 32'hAA, 1'b1, 5'd6, 32'hBB, a);
    idle(3);

    // Load burst of 6 while ALU offers 1..6, holding until accepted
    nxt = 1; acc_cnt = 0;
    for (int c = 0; c < 40 && (nxt <= 6 || sbq.size() > 0); c++) begin
      step(c < 6, 5'(10 + c), 32'h100 + c, nxt <= 6, 5'(20 + nxt), 32'(nxt), a);
      if (a) begin nxt++; if (c < 6) acc_cnt++; end
    end
    check("burst_accepted_during_load", 64'(acc_cnt), 64'd4);
    check("burst_all_accepted", 64'(nxt), 64'd7);
    idle(1);

    // Two writes to r7 buffered behind loads; lookup sees the younger one
    step(1'b1, 5'd9,  32'h900, 1'b1, 5'd7, 32'd1, a);
    step(1'b1, 5'd10, 32'h901, 1'b1, 5'd7, 32'd2, a);
    mem_valid = 0; alu_valid = 0;
    lk_addr = 5'd7; #1;
    check("lk7_hit", 64'(lk_hit), 64'd1);
    check("lk7_data", 64'(lk_data), 64'd2);
    lk_addr = 5'd8; #1;
    check("lk8_hit", 64'(lk_hit), 64'd0);
    check("lk8_data", 64'(lk_data), 64'd0);
    lk_addr = 5'd10; #1;
    check("lk10_outstage", 64'(lk_data), 64'h901);
    idle(3);

    // Fill FIFO, then mem low with ALU always offering
    nxt = 0;
    for (int c = 0; c < 40 && (nxt < 10 || sbq.size() > 0); c++) begin
      step(c < 4, 5'(1 + c), 32'h200 + c, nxt < 10, 5'(12 + nxt), 32'h300 + nxt, a);
      if (a) nxt++;
    end
    check("full_all_accepted", 64'(nxt), 64'd10);
    idle(1);

    // Reset with 3 buffered entries and a write in flight
    for (int c = 0; c < 3; c++) step(1'b1, 5'(25 + c), 32'h400 + c, 1'b1, 5'(2 + c), 32'h500 + c, a);
    check("pre_rst_count", 64'(count), 64'd3);
    mem_valid = 0; alu_valid = 1;
    #2 reset = 1'b1;
    #1;
    check("async_rst_we", 64'(gpr_we), 64'd0);
    check("async_rst_count", 64'(count), 64'd0);
    check("async_rst_ready", 64'(alu_ready), 64'd0);
    sbq.delete();
    alu_valid = 0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_drained", 64'(drained), 64'd1);
    check("post_rst_ready", 64'(alu_ready), 64'd1);
    idle(5);

    // Random traffic with a stable-until-accepted ALU producer
    pend = 0; pd = 0; pv = 0;
    for (int c = 0; c < 400; c++) begin
      if (!pend && ($urandom_range(0, 1) == 1)) begin
        pend = 1; pd = 5'($urandom); pv = $urandom;
      end
      step($urandom_range(0, 2) == 0, 5'($urandom), $urandom, pend, pd, pv, a);
      if (a) pend = 0;
    end
    for (int c = 0; c < 20 && !(sbq.size() == 0 && drained); c++) idle(1);
    check("final_drained", 64'(drained), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
